// File: rtl/sprite_pkg.sv
// sprite_pkg: shared palette, transparency index, layer enum and pipeline record types for sprite_compositor
package sprite_pkg;
  typedef logic [23:0] palette_t [16];
  localparam palette_t PALETTE = '{
    24'h101010, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFC0CB, 24'hFFFF00, 24'h800080,
    24'h808080, 24'hC0C0C0, 24'h00FFFF, 24'hFF00FF,
    24'h804000, 24'h008000, 24'h000080, 24'hFFA500
  };
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
  typedef enum logic [1:0] {L_BACKDROP, L_AREA, L_ENEMY, L_KIRBY} layer_t;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic area;
    logic kirby;
    logic enemy;
  } pipe_t;
  localparam pipe_t PIPE_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, area: 1'b0, kirby: 1'b0, enemy: 1'b0};
  typedef struct packed {
    logic [9:0] scroll_x;
    logic [9:0] kirby_x;
    logic [9:0] kirby_y;
    logic [3:0] kirby_frame;
    logic [9:0] enemy_x;
    logic [9:0] enemy_y;
    logic       enemy_on;
  } shadow_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: combinational hit test and RAM address for one sprite (in: draw_x/draw_y/de/en, pos_x/pos_y/frame; out: hit, addr)
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        de,
  input  logic        en,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [3:0]  frame,
  output logic        hit,
  output logic [17:0] addr
);
  logic [10:0] dx;
  logic [10:0] dy;
  always_comb begin
    dx   = {1'b0, draw_x} - {1'b0, pos_x};
    dy   = {1'b0, draw_y} - {1'b0, pos_y};
    hit  = de && en && !dx[10] && !dy[10] && dx < 11'(SPR_W) && dy < 11'(SPR_H);
    addr = hit ? 18'(frame) * 18'(SPR_W * SPR_H) + 18'(dy) * 18'(SPR_W) + 18'(dx) : '0;
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage pixel pipe (addresses -> RAM data -> palette RGB) with frame-latched sprite positions and aligned syncs
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int AREA_W   = 891,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int SCREEN_H = 240
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  kirby_x,
  input  logic [9:0]  kirby_y,
  input  logic [3:0]  kirby_frame,
  input  logic [9:0]  enemy_x,
  input  logic [9:0]  enemy_y,
  input  logic        enemy_on,
  output logic [17:0] area_addr,
  output logic [17:0] kirby_addr,
  output logic [17:0] enemy_addr,
  input  logic [3:0]  area_idx,
  input  logic [3:0]  kirby_idx,
  input  logic [3:0]  enemy_idx,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out
);
  logic        vs_prev_q, vs_prev_d;
  shadow_t     sh_q, sh_d;
  pipe_t       s1_q, s1_d, s2_q, s2_d;
  logic [17:0] area_addr_q, area_addr_d, kirby_addr_q, kirby_addr_d, enemy_addr_q, enemy_addr_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_out_q, de_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic        kirby_hit, enemy_hit, area_hit;
  logic [17:0] kirby_a, enemy_a;
  logic [10:0] col;
  layer_t      layer;

  sprite_addr_gen #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_kirby (
    .draw_x(DrawX), .draw_y(DrawY), .de(de_in), .en(1'b1),
    .pos_x(sh_q.kirby_x), .pos_y(sh_q.kirby_y), .frame(sh_q.kirby_frame),
    .hit(kirby_hit), .addr(kirby_a)
  );

  sprite_addr_gen #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_enemy (
    .draw_x(DrawX), .draw_y(DrawY), .de(de_in), .en(sh_q.enemy_on),
    .pos_x(sh_q.enemy_x), .pos_y(sh_q.enemy_y), .frame(4'h0),
    .hit(enemy_hit), .addr(enemy_a)
  );

  always_comb begin
    vs_prev_d    = vs_in;
    sh_d         = (vs_prev_q && !vs_in) ? '{scroll_x: scroll_x, kirby_x: kirby_x, kirby_y: kirby_y,
                                             kirby_frame: kirby_frame, enemy_x: enemy_x, enemy_y: enemy_y,
                                             enemy_on: enemy_on} : sh_q;
    col          = {1'b0, DrawX} + {1'b0, sh_q.scroll_x};
    area_hit     = de_in && col < 11'(AREA_W) && DrawY < 10'(SCREEN_H);
    area_addr_d  = area_hit ? 18'(DrawY) * 18'(AREA_W) + 18'(col) : '0;
    kirby_addr_d = kirby_a;
    enemy_addr_d = enemy_a;
    s1_d         = '{de: de_in, hs: hs_in, vs: vs_in, area: area_hit, kirby: kirby_hit, enemy: enemy_hit};
    s2_d         = s1_q;
    layer        = (s2_q.kirby && kirby_idx != TRANSPARENT_IDX) ? L_KIRBY :
                   (s2_q.enemy && enemy_idx != TRANSPARENT_IDX) ? L_ENEMY :
                   s2_q.area ? L_AREA : L_BACKDROP;
    rgb_d        = !s2_q.de ? '0 :
                   layer == L_KIRBY ? PALETTE[kirby_idx] :
                   layer == L_ENEMY ? PALETTE[enemy_idx] :
                   layer == L_AREA  ? PALETTE[area_idx]  : '0;
    de_out_d     = s2_q.de;
    hs_out_d     = s2_q.hs;
    vs_out_d     = s2_q.vs;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev_q    <= 1'b1;
      sh_q         <= '0;
      area_addr_q  <= '0;
      kirby_addr_q <= '0;
      enemy_addr_q <= '0;
      s1_q         <= PIPE_IDLE;
      s2_q         <= PIPE_IDLE;
      rgb_q        <= '0;
      de_out_q     <= 1'b0;
      hs_out_q     <= 1'b1;
      vs_out_q     <= 1'b1;
    end else begin
      vs_prev_q    <= vs_prev_d;
      sh_q         <= sh_d;
      area_addr_q  <= area_addr_d;
      kirby_addr_q <= kirby_addr_d;
      enemy_addr_q <= enemy_addr_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      rgb_q        <= rgb_d;
      de_out_q     <= de_out_d;
      hs_out_q     <= hs_out_d;
      vs_out_q     <= vs_out_d;
    end
  end

  assign area_addr  = area_addr_q;
  assign kirby_addr = kirby_addr_q;
  assign enemy_addr = enemy_addr_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign de_out     = de_out_q;
  assign hs_out     = hs_out_q;
  assign vs_out     = vs_out_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed scenario tasks checking addresses, priority, scroll, frame latch and latency
module tb_sprite_compositor;
  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, scroll_x = '0, kirby_x = '0, kirby_y = '0, enemy_x = '0, enemy_y = '0;
  logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1, enemy_on = 1'b0;
  logic [3:0]  kirby_frame = '0, area_idx = 4'd3, kirby_idx = '0, enemy_idx = '0;
  logic [17:0] area_addr, kirby_addr, enemy_addr;
  logic [7:0]  red, green, blue;
  logic        hs_out, vs_out, de_out;
  logic [17:0] aa, ka, ea;
  logic [23:0] rgb;
  logic        dd;
  int checks = 0, errors = 0;
  localparam logic [23:0] PAL [16] = '{
    24'h101010, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFC0CB, 24'hFFFF00, 24'h800080,
    24'h808080, 24'hC0C0C0, 24'h00FFFF, 24'hFF00FF,
    24'h804000, 24'h008000, 24'h000080, 24'hFFA500
  };

  sprite_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .scroll_x(scroll_x), .kirby_x(kirby_x), .kirby_y(kirby_y), .kirby_frame(kirby_frame),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_on(enemy_on),
    .area_addr(area_addr), .kirby_addr(kirby_addr), .enemy_addr(enemy_addr),
    .area_idx(area_idx), .kirby_idx(kirby_idx), .enemy_idx(enemy_idx),
    .red(red), .green(green), .blue(blue), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic latch;
    vs_in = 1'b0;
    step;
    vs_in = 1'b1;
    step;
  endtask

  task automatic run_px(input logic [9:0] x, input logic [9:0] y);
    DrawX = x; DrawY = y; de_in = 1'b1;
    step;
    aa = area_addr; ka = kirby_addr; ea = enemy_addr;
    de_in = 1'b0;
    step;
    step;
    rgb = {red, green, blue}; dd = de_out;
  endtask

  task automatic test_reset;
    repeat (3) step;
    checks++; if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h exp 000000", {red, green, blue}); end
    checks++; if ({hs_out, vs_out, de_out} !== 3'b110) begin errors++; $display("FAIL reset_sync got %b exp 110", {hs_out, vs_out, de_out}); end
    Reset_n = 1'b1;
    DrawX = 10'd40; DrawY = 10'd0; de_in = 1'b1;
    step;
    checks++; if (area_addr !== 18'd40) begin errors++; $display("FAIL post_reset_area_addr got %0d exp 40", area_addr); end
    step;
    checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL latency_t2_de got %b exp 0", de_out); end
    step;
    checks++; if (de_out !== 1'b1 || {red, green, blue} !== PAL[3]) begin errors++; $display("FAIL latency_t3 got de=%b rgb=%h exp de=1 rgb=%h", de_out, {red, green, blue}, PAL[3]); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({red, green, blue} !== 24'h0 || {hs_out, vs_out, de_out} !== 3'b110 || area_addr !== 18'd0) begin errors++; $display("FAIL midline_reset got rgb=%h syncs=%b addr=%0d exp 000000 110 0", {red, green, blue}, {hs_out, vs_out, de_out}, area_addr); end
    repeat (5) step;
    checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL reset_hold_de got %b exp 0", de_out); end
    Reset_n = 1'b1;
    step;
    step;
    checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL release_t2_de got %b exp 0", de_out); end
    step;
    checks++; if (de_out !== 1'b1 || {red, green, blue} !== PAL[3]) begin errors++; $display("FAIL release_t3 got de=%b rgb=%h exp de=1 rgb=%h", de_out, {red, green, blue}, PAL[3]); end
    de_in = 1'b0;
    repeat (3) step;
  endtask

  task automatic test_sync;
    hs_in = 1'b0; vs_in = 1'b0;
    step;
    hs_in = 1'b1; vs_in = 1'b1;
    step;
    checks++; if ({hs_out, vs_out} !== 2'b11) begin errors++; $display("FAIL sync_t2 got %b exp 11", {hs_out, vs_out}); end
    step;
    checks++; if ({hs_out, vs_out} !== 2'b00) begin errors++; $display("FAIL sync_t3 got %b exp 00", {hs_out, vs_out}); end
    step;
    checks++; if ({hs_out, vs_out} !== 2'b11) begin errors++; $display("FAIL sync_t4 got %b exp 11", {hs_out, vs_out}); end
  endtask

  task automatic test_kirby;
    kirby_x = 10'd100; kirby_y = 10'd50; kirby_frame = 4'd2; enemy_on = 1'b0; scroll_x = '0;
    latch;
    kirby_idx = 4'd5; area_idx = 4'd3;
    run_px(10'd103, 10'd52);
    checks++; if (ka !== 18'd2115) begin errors++; $display("FAIL kirby_addr got %0d exp 2115", ka); end
    checks++; if (aa !== 18'd46435) begin errors++; $display("FAIL kirby_area_addr got %0d exp 46435", aa); end
    checks++; if (rgb !== PAL[5] || dd !== 1'b1) begin errors++; $display("FAIL kirby_rgb got %h de=%b exp %h de=1", rgb, dd, PAL[5]); end
    run_px(10'd132, 10'd52);
    checks++; if (ka !== 18'd0 || rgb !== PAL[3]) begin errors++; $display("FAIL kirby_right_edge got addr=%0d rgb=%h exp 0 %h", ka, rgb, PAL[3]); end
    run_px(10'd131, 10'd81);
    checks++; if (ka !== 18'd3071) begin errors++; $display("FAIL kirby_corner got %0d exp 3071", ka); end
  endtask

  task automatic test_overlap;
    enemy_x = 10'd96; enemy_y = 10'd48; enemy_on = 1'b1;
    latch;
    kirby_idx = 4'd0; enemy_idx = 4'd7; area_idx = 4'd3;
    run_px(10'd103, 10'd52);
    checks++; if (ea !== 18'd135) begin errors++; $display("FAIL enemy_addr got %0d exp 135", ea); end
    checks++; if (rgb !== PAL[7]) begin errors++; $display("FAIL kirby_transparent got %h exp %h", rgb, PAL[7]); end
    kirby_idx = 4'd2;
    run_px(10'd103, 10'd52);
    checks++; if (rgb !== PAL[2]) begin errors++; $display("FAIL kirby_priority got %h exp %h", rgb, PAL[2]); end
    kirby_idx = 4'd0; enemy_idx = 4'd0;
    run_px(10'd103, 10'd52);
    checks++; if (rgb !== PAL[3]) begin errors++; $display("FAIL both_transparent got %h exp %h", rgb, PAL[3]); end
    area_idx = 4'd0;
    run_px(10'd103, 10'd52);
    checks++; if (rgb !== PAL[0]) begin errors++; $display("FAIL area_idx0_opaque got %h exp %h", rgb, PAL[0]); end
    enemy_on = 1'b0; enemy_idx = 4'd7; area_idx = 4'd3;
    latch;
    run_px(10'd103, 10'd52);
    checks++; if (ea !== 18'd0 || rgb !== PAL[3]) begin errors++; $display("FAIL enemy_off got addr=%0d rgb=%h exp 0 %h", ea, rgb, PAL[3]); end
  endtask

  task automatic test_scroll;
    kirby_idx = 4'd0; area_idx = 4'd3;
    scroll_x = 10'd880;
    latch;
    run_px(10'd20, 10'd5);
    checks++; if (aa !== 18'd0 || rgb !== 24'h0 || dd !== 1'b1) begin errors++; $display("FAIL scroll_past_end got addr=%0d rgb=%h de=%b exp 0 000000 1", aa, rgb, dd); end
    scroll_x = 10'd870;
    latch;
    run_px(10'd20, 10'd1);
    checks++; if (aa !== 18'd1781 || rgb !== PAL[3]) begin errors++; $display("FAIL scroll_last_col got addr=%0d rgb=%h exp 1781 %h", aa, rgb, PAL[3]); end
    scroll_x = 10'd0;
    latch;
    run_px(10'd20, 10'd1);
    checks++; if (aa !== 18'd911) begin errors++; $display("FAIL area_addr_row1 got %0d exp 911", aa); end
    run_px(10'd20, 10'd240);
    checks++; if (aa !== 18'd0 || rgb !== 24'h0) begin errors++; $display("FAIL area_below_screen got addr=%0d rgb=%h exp 0 000000", aa, rgb); end
  endtask

  task automatic test_shadow;
    kirby_x = 10'd200; kirby_idx = 4'd5;
    run_px(10'd103, 10'd52);
    checks++; if (ka !== 18'd2115) begin errors++; $display("FAIL shadow_hold got %0d exp 2115", ka); end
    latch;
    run_px(10'd203, 10'd52);
    checks++; if (ka !== 18'd2115) begin errors++; $display("FAIL shadow_new got %0d exp 2115", ka); end
    run_px(10'd103, 10'd52);
    checks++; if (ka !== 18'd0) begin errors++; $display("FAIL shadow_old_pos got %0d exp 0", ka); end
  endtask

  task automatic test_nowrap;
    kirby_x = 10'd1020; kirby_y = 10'd0; kirby_frame = 4'd0; kirby_idx = 4'd5; area_idx = 4'd3;
    latch;
    run_px(10'd4, 10'd0);
    checks++; if (ka !== 18'd0 || rgb !== PAL[3]) begin errors++; $display("FAIL no_wrap got addr=%0d rgb=%h exp 0 %h", ka, rgb, PAL[3]); end
    run_px(10'd1021, 10'd0);
    checks++; if (ka !== 18'd1 || aa !== 18'd0 || rgb !== PAL[5]) begin errors++; $display("FAIL right_edge_sprite got k=%0d a=%0d rgb=%h exp 1 0 %h", ka, aa, rgb, PAL[5]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_sync;
    test_kirby;
    test_overlap;
    test_scroll;
    test_shadow;
    test_nowrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
